// File: rtl/product_accumulator.sv
// product_accumulator: buffers multiplier products in a small FIFO and emits
// saturating sums of each BLOCK_LEN-product group on a valid/ready handshake.
`default_nettype none

module product_accumulator #(
  parameter int DATA_W     = 32,
  parameter int ACC_W      = 40,
  parameter int BLOCK_LEN  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [DATA_W-1:0]                prod_i,
  input  logic                             prod_vld_i,
  input  logic                             clear_i,
  output logic [ACC_W-1:0]                 sum_o,
  output logic                             sum_sat_o,
  output logic                             sum_vld_o,
  input  logic                             sum_rdy_i,
  output logic [$clog2(BLOCK_LEN+1)-1:0]   count_o,
  output logic                             drop_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(BLOCK_LEN+1);
  localparam int SW = ACC_W + 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(BLOCK_LEN - 1);

  typedef enum logic [0:0] {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  state_t state, state_next;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr;
  logic              fifo_empty, fifo_full, pop, push, flush;

  logic [ACC_W-1:0]  acc, acc_next;
  logic [SW-1:0]     acc_sum;
  logic              sat, sat_next, block_done;
  logic [CW-1:0]     count;

  assign flush      = rst || clear_i;
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop        = (state == ACCUM) && !fifo_empty;
  // A full FIFO still takes a product when a slot frees up in the same cycle.
  assign push       = prod_vld_i && (!fifo_full || pop);

  assign acc_sum    = {1'b0, acc} + SW'(mem[rd_ptr[AW-1:0]]);
  assign acc_next   = acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
  assign sat_next   = sat | acc_sum[ACC_W];
  assign block_done = pop && (count == LAST_COUNT);
  assign count_o    = count;

  always_ff @(posedge clk) begin
    if (flush) state <= ACCUM;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ACCUM:   if (block_done) state_next = HOLD;
      HOLD:    if (sum_vld_o && sum_rdy_i) state_next = ACCUM;
      default: state_next = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= prod_i;
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      acc       <= '0;
      sat       <= 1'b0;
      count     <= '0;
      sum_o     <= '0;
      sum_sat_o <= 1'b0;
      sum_vld_o <= 1'b0;
      drop_o    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (prod_vld_i && !push) drop_o <= 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
        if (block_done) begin
          sum_o     <= acc_next;
          sum_sat_o <= sat_next;
          sum_vld_o <= 1'b1;
          acc       <= '0;
          sat       <= 1'b0;
          count     <= '0;
        end else begin
          acc   <= acc_next;
          sat   <= sat_next;
          count <= count + CW'(1);
        end
      end else if (state == HOLD && sum_vld_o && sum_rdy_i) begin
        sum_vld_o <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/product_accumulator.md
Name: product_accumulator

Overview:
- Downstream consumer of the shift-multiplier result stream; one instance per multiplier lane.
- Captures every valid product into a small input FIFO, since the multiplier has no backpressure.
- Sums each group of BLOCK_LEN products into a saturating accumulator.
- Presents each block sum on a valid/ready output handshake and holds it until the sum is accepted.

Parameters:
- DATA_W, 32, product width; matches the multiplier c output.
- ACC_W, 40, accumulator and sum width; must be >= DATA_W.
- BLOCK_LEN, 8, number of products per output sum; must be >= 1.
- FIFO_DEPTH, 4, input FIFO entries; must be a power of 2 and >= 2.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- prod_i  in  DATA_W  product from multiplier, unsigned.
- prod_vld_i  in  1  product valid; single-cycle pulse per product, no ready.
- clear_i  in  1  synchronous flush, same effect as rst.
- sum_o  out  ACC_W  block sum.
- sum_sat_o  out  1  sum_o saturated; qualified by sum_vld_o.
- sum_vld_o  out  1  sum_o valid.
- sum_rdy_i  in  1  downstream accepts sum_o.
- count_o  out  $clog2(BLOCK_LEN+1)  products accumulated in current block.
- drop_o  out  1  sticky: at least one product was lost to a full FIFO.

Behaviour:
- Reset/clear: on rst or clear_i high at an edge:
  - FIFO emptied; accumulator, count_o, sum_o, sum_sat_o, sum_vld_o and drop_o all 0; state ACCUM.
  - rst and clear_i take priority over every other event, including mid-handshake and while in HOLD.
- FIFO push:
  - prod_vld_i is accepted when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
  - Otherwise the product is discarded and drop_o is set to 1 at that edge.
  - drop_o stays 1 until rst or clear_i.
- FIFO pop: occurs only in state ACCUM when the FIFO is non-empty (registered occupancy); at most one pop per cycle.
- Pass-through: a write to an empty FIFO is not visible until the next cycle, so there is no same-cycle pass-through.
- State ACCUM, per pop:
  - acc_next = acc + zero-extended entry.
  - If the true sum exceeds 2^ACC_W-1, acc_next = all-ones and the block's sat flag is set; saturation is sticky for the rest of the block.
  - count increments by 1.
- Block completion: when a pop brings count to BLOCK_LEN, at the same edge:
  - sum_o <= acc_next and sum_sat_o <= the block's sat flag.
  - sum_vld_o <= 1.
  - acc, count and the sat flag are cleared; state goes to HOLD.
- State HOLD:
  - No pops; the FIFO still accepts pushes.
  - sum_o, sum_sat_o and sum_vld_o are held stable.
  - On sum_vld_o && sum_rdy_i: sum_vld_o <= 0 at that edge, state goes to ACCUM, and popping resumes the following cycle.
- sum_rdy_i is ignored while sum_vld_o == 0.
- Latency:
  - A product pushed in cycle t is popped in cycle t+1 at the earliest.
  - If it is the block's last product, sum_vld_o is high from cycle t+2.
  - Throughput in ACCUM is one product per cycle.
- count_o reflects the registered count: 0..BLOCK_LEN-1 in ACCUM, 0 in HOLD.
- Arithmetic: all values unsigned; no wrap-around, only saturation.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits.
- Full/empty are derived from pointer compare, and pointer wrap must be correct across many blocks.

Test Plan:
- Defaults, sum_rdy_i=1, push products 1..8 on consecutive cycles t..t+7:
  - sum_vld_o high exactly in cycle t+9.
  - sum_o=36, sum_sat_o=0, drop_o=0.
- sum_rdy_i=0 for 12 cycles after the first sum, with 4 more products pushed meanwhile:
  - sum_o=36 stays stable and valid; no drop.
  - After rdy rises, count_o reaches 4 within 4 cycles.
- sum_rdy_i=0, first block complete, push 6 products (FIFO_DEPTH=4):
  - 2 products discarded; drop_o=1 and stays 1 until clear_i pulse, then drop_o=0.
- ACC_W=34, 8 products of 0xFFFF_FFFF:
  - sum_o=0x3_FFFF_FFFF, sum_sat_o=1.
  - Next block of eight 1's gives sum_o=8, sum_sat_o=0.
- 3 products of 5 then clear_i; then 8 products of 2:
  - count_o=0 after clear, sum_o=16.
  - No stale data appears.
- rst asserted while in HOLD with sum_vld_o=1:
  - sum_vld_o=0 and count_o=0 in the next cycle.
  - FIFO empty, and a subsequent block sums correctly.
